// File: rtl/lcd_frame_sequencer_pkg.sv
// Shared definitions for the LCD frame sequencer: engine modes, FSM states,
// and a constant-evaluable ceil(log2) helper.
package lcd_pkg;

  localparam logic LCD_INIT = 1'b0;
  localparam logic LCD_REF  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    INIT_W,
    ADDR,
    ADDR_W,
    REF,
    REF_W,
    GAP
  } state_t;

  function automatic int CLOG2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/lcd_frame_sequencer_if.sv
// Sequencer <-> write-engine control bundle; master is the sequencer side,
// slave is the engine/top-level side.
interface lcd_frame_sequencer_if #(
  parameter int CNT_W  = 5,
  parameter int LINE_W = 1
);

  logic              lcd_finish;
  logic              reinit;
  logic              reg_sel;
  logic              mode;
  logic [CNT_W-1:0]  lcd_cnt;
  logic              lcd_enable;
  logic              data_sel;
  logic              DB_sel;
  logic [LINE_W-1:0] line_sel;
  logic              frame_done;
  logic              fault;

  modport master (
    input  lcd_finish, reinit,
    output reg_sel, mode, lcd_cnt, lcd_enable, data_sel, DB_sel,
           line_sel, frame_done, fault
  );

  modport slave (
    output lcd_finish, reinit,
    input  reg_sel, mode, lcd_cnt, lcd_enable, data_sel, DB_sel,
           line_sel, frame_done, fault
  );

endinterface

// File: rtl/lcd_frame_sequencer_wait_timer.sv
// Loadable saturating down-counter; serves both the inter-frame gap and the
// lcd_finish watchdog since those two never run at the same time.
module lcd_wait_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_loadVal,
  input  logic         i_en,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/lcd_frame_sequencer.sv
// Moore sequencer driving the LCD write engine: init once, then repeating
// multi-line refresh frames with an optional gap, re-init and a finish watchdog.
module lcd_frame_sequencer
  import lcd_pkg::*;
#(
  parameter int INIT_CONST_NO = 4,
  parameter int REF_DATA_NO   = 16,
  parameter int LINES         = 2,
  parameter int CNT_W         = 5,
  parameter int GAP_CYCLES    = 1000,
  parameter int FIN_TIMEOUT   = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  lcd_frame_sequencer_if.master bus
);

  localparam int LINE_W  = (LINES > 1) ? CLOG2(LINES) : 1;
  localparam int TMR_MAX = (FIN_TIMEOUT > GAP_CYCLES) ? FIN_TIMEOUT : GAP_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? CLOG2(TMR_MAX + 1) : 1;

  localparam logic [TMR_W-1:0]  FIN_LOAD  = TMR_W'((FIN_TIMEOUT > 0) ? FIN_TIMEOUT - 1 : 0);
  localparam logic [TMR_W-1:0]  GAP_LOAD  = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);
  localparam logic [CNT_W-1:0]  INIT_CNT  = CNT_W'(INIT_CONST_NO - 1);
  localparam logic [CNT_W-1:0]  REF_CNT   = CNT_W'(REF_DATA_NO - 1);

  state_t             r_state;
  state_t             w_nextState;
  logic [LINE_W-1:0]  r_line;
  logic [LINE_W-1:0]  w_nextLine;
  logic               r_frameDone;
  logic               w_frameDone;
  logic               r_fault;
  logic               w_timeout;
  logic               w_tmrLoad;
  logic [TMR_W-1:0]   w_tmrLoadVal;
  logic               w_tmrEn;
  logic               w_tmrDone;

  logic               w_regSel;
  logic               w_mode;
  logic [CNT_W-1:0]   w_lcdCnt;
  logic               w_lcdEnable;
  logic               w_dataSel;
  logic               w_dbSel;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_line      <= '0;
      r_frameDone <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_line      <= w_nextLine;
      r_frameDone <= w_frameDone;
      if (w_timeout) r_fault <= 1'b1;
    end
  end

  // lcd_finish is only looked at in the wait states, so a pulse that lands
  // on an enable cycle or during GAP falls through untouched.
  always_comb begin
    w_nextState = r_state;
    w_nextLine  = r_line;
    w_frameDone = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE:   w_nextState = INIT;
      INIT:   w_nextState = INIT_W;
      INIT_W: begin
        if (bus.lcd_finish) begin
          w_nextState = ADDR;
          w_nextLine  = '0;
        end else if (w_tmrDone) begin
          w_timeout = 1'b1;
        end
      end
      ADDR:   w_nextState = ADDR_W;
      ADDR_W: begin
        if (bus.lcd_finish)     w_nextState = REF;
        else if (w_tmrDone)     w_timeout   = 1'b1;
      end
      REF:    w_nextState = REF_W;
      REF_W: begin
        if (bus.lcd_finish) begin
          if (bus.reinit) begin
            w_nextState = INIT;
          end else if (r_line < LAST_LINE) begin
            w_nextState = ADDR;
            w_nextLine  = r_line + 1'b1;
          end else begin
            w_nextState = (GAP_CYCLES == 0) ? ADDR : GAP;
            w_nextLine  = '0;
            w_frameDone = 1'b1;
          end
        end else if (w_tmrDone) begin
          w_timeout = 1'b1;
        end
      end
      GAP: begin
        if (bus.reinit)      w_nextState = INIT;
        else if (w_tmrDone)  w_nextState = ADDR;
      end
      default: w_nextState = IDLE;
    endcase
    if (w_timeout) w_nextState = INIT;
    if (w_nextState == INIT) w_nextLine = '0;
  end

  always_comb begin
    w_tmrLoad    = (w_nextState != r_state);
    w_tmrLoadVal = (w_nextState == GAP) ? GAP_LOAD : FIN_LOAD;
    w_tmrEn      = (r_state == INIT_W) || (r_state == ADDR_W) ||
                   (r_state == REF_W)  || (r_state == GAP);
  end

  lcd_wait_timer #(.W(TMR_W)) u_waitTimer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_tmrLoad),
    .i_loadVal (w_tmrLoadVal),
    .i_en      (w_tmrEn),
    .o_done    (w_tmrDone)
  );

  always_comb begin
    w_regSel    = 1'b0;
    w_mode      = LCD_INIT;
    w_lcdCnt    = INIT_CNT;
    w_lcdEnable = 1'b0;
    w_dataSel   = 1'b0;
    w_dbSel     = 1'b1;
    case (r_state)
      INIT: w_lcdEnable = 1'b1;
      ADDR: begin
        w_lcdEnable = 1'b1;
        w_dbSel     = 1'b0;
        w_lcdCnt    = '0;
      end
      ADDR_W: begin
        w_dbSel  = 1'b0;
        w_lcdCnt = '0;
      end
      REF, REF_W: begin
        w_lcdEnable = (r_state == REF);
        w_regSel    = 1'b1;
        w_dataSel   = 1'b1;
        w_mode      = LCD_REF;
        w_lcdCnt    = REF_CNT;
      end
      default: ;
    endcase
  end

  assign bus.reg_sel    = w_regSel;
  assign bus.mode       = w_mode;
  assign bus.lcd_cnt    = w_lcdCnt;
  assign bus.lcd_enable = w_lcdEnable;
  assign bus.data_sel   = w_dataSel;
  assign bus.DB_sel     = w_dbSel;
  assign bus.line_sel   = r_line;
  assign bus.frame_done = r_frameDone;
  assign bus.fault      = r_fault;

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Scoreboard bench: two sequencer instances (2 lines / 6-cycle gap, and
// 4 lines / no gap), each with a 20-cycle watchdog, exercised one at a time.
module tb_lcd_frame_sequencer;

  localparam int K_INIT = 0;
  localparam int K_ADDR = 1;
  localparam int K_REF  = 2;

  typedef struct packed {
    logic        mode;
    logic [4:0]  cnt;
    logic        regSel;
    logic        dataSel;
    logic        dbSel;
    logic [1:0]  line;
    logic        fault;
    logic [15:0] interval;
    logic [7:0]  frames;
  } xfer_t;

  logic clk;
  logic rstA, rstB;
  logic act;
  logic finishDrv;
  logic reinit;
  logic glitchEn;
  logic withholdReq;
  logic withheld;

  int vectors;
  int miscompares;
  xfer_t expQ[$];

  lcd_frame_sequencer_if #(.CNT_W(5), .LINE_W(1)) busA ();
  lcd_frame_sequencer_if #(.CNT_W(5), .LINE_W(2)) busB ();

  assign busA.lcd_finish = finishDrv;
  assign busA.reinit     = reinit;
  assign busB.lcd_finish = finishDrv;
  assign busB.reinit     = reinit;

  lcd_frame_sequencer #(
    .INIT_CONST_NO(4), .REF_DATA_NO(16), .LINES(2), .CNT_W(5),
    .GAP_CYCLES(6), .FIN_TIMEOUT(20)
  ) dutA (
    .clk(clk), .rst(rstA), .bus(busA)
  );

  lcd_frame_sequencer #(
    .INIT_CONST_NO(4), .REF_DATA_NO(16), .LINES(4), .CNT_W(5),
    .GAP_CYCLES(0), .FIN_TIMEOUT(20)
  ) dutB (
    .clk(clk), .rst(rstB), .bus(busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       oEn, oMode, oRegSel, oDataSel, oDbSel, oFault, oFrameDone, oRst;
  logic [4:0] oCnt;
  logic [1:0] oLine;

  always_comb begin
    oRst       = act ? rstB            : rstA;
    oEn        = act ? busB.lcd_enable : busA.lcd_enable;
    oMode      = act ? busB.mode       : busA.mode;
    oCnt       = act ? busB.lcd_cnt    : busA.lcd_cnt;
    oRegSel    = act ? busB.reg_sel    : busA.reg_sel;
    oDataSel   = act ? busB.data_sel   : busA.data_sel;
    oDbSel     = act ? busB.DB_sel     : busA.DB_sel;
    oLine      = act ? busB.line_sel   : {1'b0, busA.line_sel};
    oFault     = act ? busB.fault      : busA.fault;
    oFrameDone = act ? busB.frame_done : busA.frame_done;
  end

  function automatic xfer_t makeRec(input int kind, input int line, input bit fault,
                                    input int interval, input int frames);
    xfer_t r;
    r = '0;
    case (kind)
      K_INIT: begin r.mode = 1'b0; r.cnt = 5'd3;  r.regSel = 1'b0; r.dataSel = 1'b0; r.dbSel = 1'b1; end
      K_ADDR: begin r.mode = 1'b0; r.cnt = 5'd0;  r.regSel = 1'b0; r.dataSel = 1'b0; r.dbSel = 1'b0; end
      default: begin r.mode = 1'b1; r.cnt = 5'd15; r.regSel = 1'b1; r.dataSel = 1'b1; r.dbSel = 1'b1; end
    endcase
    r.line     = 2'(line);
    r.fault    = fault;
    r.interval = 16'(interval);
    r.frames   = 8'(frames);
    return r;
  endfunction

  // interval = negedges since the previous enable (or since the last reset cycle)
  task automatic applyStimulus(input int kind, input int line, input bit fault,
                               input int interval, input int frames);
    expQ.push_back(makeRec(kind, line, fault, interval, frames));
  endtask

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, got, expv, $time);
    end
  endtask

  task automatic drain();
    while (expQ.size() != 0) @(negedge clk);
  endtask

  // Engine model: finish arrives 10 cycles after each enable; optional
  // stray pulses on the enable cycle and in the first GAP cycle.
  initial begin
    finishDrv = 1'b0;
    withheld  = 1'b0;
    forever begin
      @(negedge clk);
      while (oEn && oRst) begin
        if (withholdReq && !withheld && !oDbSel) begin
          withheld = 1'b1;
          break;
        end
        if (glitchEn) begin
          finishDrv = 1'b1;
          @(negedge clk);
          finishDrv = 1'b0;
          repeat (9) @(negedge clk);
        end else begin
          repeat (10) @(negedge clk);
        end
        finishDrv = 1'b1;
        @(negedge clk);
        finishDrv = 1'b0;
        if (glitchEn && oFrameDone) begin
          finishDrv = 1'b1;
          @(negedge clk);
          finishDrv = 1'b0;
        end
      end
    end
  end

  // Monitor: reset defaults while held in reset, scoreboard pop on every enable.
  initial begin
    int cycle, lastEn, idle, frames;
    logic rstPrev;
    xfer_t e, got;
    cycle = 0; lastEn = 0; idle = 0; frames = 0; rstPrev = 1'b1;
    vectors = 0; miscompares = 0;
    forever begin
      @(negedge clk);
      cycle++;
      if (!oRst) begin
        if (!rstPrev)
          checkOutput("reset_defaults",
                      64'({oEn, oMode, oCnt, oRegSel, oDataSel, oDbSel, oLine, oFault, oFrameDone}),
                      64'({1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0}));
        frames = 0;
        lastEn = cycle;
        idle   = 0;
      end else begin
        if (oFrameDone) frames++;
        if (oEn) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_enable", 64'(oEn), 64'(0));
          end else begin
            e = expQ.pop_front();
            got.mode = oMode; got.cnt = oCnt; got.regSel = oRegSel; got.dataSel = oDataSel;
            got.dbSel = oDbSel; got.line = oLine; got.fault = oFault;
            got.interval = 16'(cycle - lastEn); got.frames = 8'(frames);
            checkOutput("transfer", 64'(got), 64'(e));
          end
          lastEn = cycle;
          idle   = 0;
        end else if (expQ.size() != 0) begin
          idle++;
          if (idle > 100) begin
            checkOutput("enable_timeout", 64'(expQ.size()), 64'(0));
            expQ.delete();
            idle = 0;
          end
        end
      end
      rstPrev = oRst;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: simulation still running at t=%0t, limit 300000", $time);
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    rstA = 1'b0; rstB = 1'b0; act = 1'b0; reinit = 1'b0;
    glitchEn = 1'b1; withholdReq = 1'b0;

    // DUT A: 2 lines, 6-cycle gap, stray finish pulses throughout
    repeat (3) @(posedge clk);
    #1 rstA = 1'b1;
    applyStimulus(K_INIT, 0, 0, 2, 0);
    applyStimulus(K_ADDR, 0, 0, 11, 0);
    applyStimulus(K_REF,  0, 0, 11, 0);
    applyStimulus(K_ADDR, 1, 0, 11, 0);
    applyStimulus(K_REF,  1, 0, 11, 0);
    applyStimulus(K_ADDR, 0, 0, 17, 1);
    applyStimulus(K_REF,  0, 0, 11, 1);
    drain();

    // reinit raised mid-burst on line 0: burst finishes, then INIT
    @(posedge clk); #1 reinit = 1'b1;
    applyStimulus(K_INIT, 0, 0, 11, 1);
    drain();
    @(posedge clk); #1 reinit = 1'b0;
    withholdReq = 1'b1;

    // next ADDR never finishes: 20 wait cycles, then faulted INIT
    applyStimulus(K_ADDR, 0, 0, 11, 1);
    applyStimulus(K_INIT, 0, 1, 21, 1);
    applyStimulus(K_ADDR, 0, 1, 11, 1);
    applyStimulus(K_REF,  0, 1, 11, 1);
    applyStimulus(K_ADDR, 1, 1, 11, 1);
    applyStimulus(K_REF,  1, 1, 11, 1);
    applyStimulus(K_ADDR, 0, 1, 17, 2);
    drain();

    @(posedge clk); #1 rstA = 1'b0;
    repeat (4) @(posedge clk);
    #1 act = 1'b1; glitchEn = 1'b0;
    repeat (12) @(posedge clk);

    // DUT B: 4 lines, no gap -> frame_done coincides with the ADDR enable
    #1 rstB = 1'b1;
    applyStimulus(K_INIT, 0, 0, 2, 0);
    for (int l = 0; l < 4; l++) begin
      applyStimulus(K_ADDR, l, 0, 11, 0);
      applyStimulus(K_REF,  l, 0, 11, 0);
    end
    applyStimulus(K_ADDR, 0, 0, 11, 1);
    applyStimulus(K_REF,  0, 0, 11, 1);
    drain();

    @(posedge clk); #1 rstB = 1'b0;
    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
